// File: rtl/jtkiwi_gfx_romslot.sv
// ---------------------------------------------------------------------------
// jtkiwi_gfx_romslot
//
// Responder side of the 32-bit graphics ROM fetch interface used by the
// tilemap and object engines. Each 32-bit word request becomes a two-beat
// 16-bit SDRAM read; the two beats are assembled as {beat1, beat0}. A
// one-entry tag cache returns repeated reads of the same word without
// touching SDRAM. One instance per client.
//
// Parameters
//   AW      width of slot_addr (32-bit word address)
//   OFFSET  16-bit-word base of this ROM region inside SDRAM
//
// Ports
//   rst         asynchronous reset, active-high
//   clk         system clock, rising edge
//   slot_addr   requested 32-bit word address
//   slot_cs     request strobe (level, held until slot_ok)
//   slot_ok     slot_data is valid for the current slot_addr
//   slot_data   assembled word {beat1, beat0}
//   sdram_addr  16-bit word address {slot_addr,1'b0} + OFFSET (22-bit wrap)
//   sdram_req   read request, held until sdram_ack
//   sdram_ack   one-cycle accept pulse
//   sdram_dst   one-cycle data strobe per 16-bit beat
//   sdram_din   read data, valid with sdram_dst
// ---------------------------------------------------------------------------
module jtkiwi_gfx_romslot #(
    parameter int          AW     = 18,
    parameter logic [21:0] OFFSET = 22'h0
) (
    input  logic          rst,
    input  logic          clk,
    input  logic [AW-1:0] slot_addr,
    input  logic          slot_cs,
    output logic          slot_ok,
    output logic [31:0]   slot_data,
    output logic [21:0]   sdram_addr,
    output logic          sdram_req,
    input  logic          sdram_ack,
    input  logic          sdram_dst,
    input  logic [15:0]   sdram_din
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BEAT0 = 2'd2,
        BEAT1 = 2'd3
    } state_t;

    state_t        state;
    logic [AW-1:0] tag;
    logic [AW-1:0] req_addr;
    logic          valid;
    logic [31:0]   data;
    logic          hit;
    logic [21:0]   fetch_addr;

    // Byte-pair address of the requested word, wrapped to the 22-bit SDRAM space
    assign fetch_addr = 22'({slot_addr, 1'b0}) + OFFSET;

    assign hit       = valid && (tag == slot_addr);
    // Only an idle slot may flag ok, so a fill in progress never exposes stale data
    assign slot_ok   = slot_cs && hit && (state == IDLE);
    assign slot_data = data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tag        <= '0;
            req_addr   <= '0;
            valid      <= 1'b0;
            data       <= '0;
            sdram_addr <= '0;
            sdram_req  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (slot_cs && !hit) begin
                        req_addr   <= slot_addr;
                        sdram_addr <= fetch_addr;
                        sdram_req  <= 1'b1;
                        valid      <= 1'b0;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        // A strobe arriving with the ack is already the first beat
                        if (sdram_dst) begin
                            data[15:0] <= sdram_din;
                            state      <= BEAT1;
                        end else begin
                            state      <= BEAT0;
                        end
                    end
                end
                BEAT0: begin
                    if (sdram_dst) begin
                        data[15:0] <= sdram_din;
                        state      <= BEAT1;
                    end
                end
                BEAT1: begin
                    // The burst always completes; the cache takes the latched
                    // address even if the client has moved on meanwhile
                    if (sdram_dst) begin
                        data[31:16] <= sdram_din;
                        tag         <= req_addr;
                        valid       <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtkiwi_gfx_romslot.sv
module tb_jtkiwi_gfx_romslot;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Instance 0: OFFSET = 0
    logic [17:0] addr0 = '0;
    logic        cs0 = 1'b0, ok0;
    logic [31:0] data0;
    logic [21:0] saddr0;
    logic        req0, ack0 = 1'b0, dst0 = 1'b0;
    logic [15:0] din0 = '0;

    // Instance 1: OFFSET near the top of the SDRAM space
    logic [17:0] addr1 = '0;
    logic        cs1 = 1'b0, ok1;
    logic [31:0] data1;
    logic [21:0] saddr1;
    logic        req1, ack1 = 1'b0, dst1 = 1'b0;
    logic [15:0] din1 = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic        ok0_q = 1'b0, ok1_q = 1'b0;

    always #5 clk = ~clk;

    jtkiwi_gfx_romslot #(.AW(18), .OFFSET(22'h0)) u0 (
        .rst(rst), .clk(clk),
        .slot_addr(addr0), .slot_cs(cs0), .slot_ok(ok0), .slot_data(data0),
        .sdram_addr(saddr0), .sdram_req(req0), .sdram_ack(ack0),
        .sdram_dst(dst0), .sdram_din(din0)
    );

    jtkiwi_gfx_romslot #(.AW(18), .OFFSET(22'h3FFFFE)) u1 (
        .rst(rst), .clk(clk),
        .slot_addr(addr1), .slot_cs(cs1), .slot_ok(ok1), .slot_data(data1),
        .sdram_addr(saddr1), .sdram_req(req1), .sdram_ack(ack1),
        .sdram_dst(dst1), .sdram_din(din1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: each new slot_ok presentation consumes one expected word
    always @(negedge clk) begin
        if (ok0 && !ok0_q) begin
            if (q0.size() == 0) chk("u0 unexpected ok", 32'd1, 32'd0);
            else                chk("u0 ok data", data0, q0.pop_front());
        end
        if (ok1 && !ok1_q) begin
            if (q1.size() == 0) chk("u1 unexpected ok", 32'd1, 32'd0);
            else                chk("u1 ok data", data1, q1.pop_front());
        end
        ok0_q = ok0;
        ok1_q = ok1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic let_monitor;
        @(negedge clk);
        #1;
    endtask

    initial begin
        // 1: reset state and first request
        #12;
        chk("rst req", 32'(req0), 32'd0);
        chk("rst addr", 32'(saddr0), 32'd0);
        chk("rst data", data0, 32'd0);
        rst = 1'b0;
        tick;
        cs0 = 1'b1; addr0 = 18'h00010;
        #1;
        chk("miss ok low", 32'(ok0), 32'd0);
        tick;
        chk("req issued", 32'(req0), 32'd1);
        chk("req addr", 32'(saddr0), 32'h20);

        // 2: two-beat fill
        q0.push_back(32'hABCD1234);
        ack0 = 1'b1;
        tick;
        ack0 = 1'b0;
        chk("req drop on ack", 32'(req0), 32'd0);
        dst0 = 1'b1; din0 = 16'h1234;
        tick;
        chk("ok low mid fill", 32'(ok0), 32'd0);
        din0 = 16'hABCD;
        tick;
        dst0 = 1'b0;
        chk("ok after fill", 32'(ok0), 32'd1);
        let_monitor;

        // 3: hit after dropping cs for one cycle
        cs0 = 1'b0;
        let_monitor;
        chk("ok low cs low", 32'(ok0), 32'd0);
        q0.push_back(32'hABCD1234);
        tick;
        cs0 = 1'b1;
        #1;
        chk("hit same cycle", 32'(ok0), 32'd1);
        chk("hit no req", 32'(req0), 32'd0);
        let_monitor;
        tick;
        chk("hit still no req", 32'(req0), 32'd0);

        // 4: address change during BEAT0
        rst = 1'b1;
        #2;
        rst = 1'b0;
        let_monitor;
        addr0 = 18'h00010; cs0 = 1'b1;
        tick;
        chk("t4 req addr", 32'(saddr0), 32'h20);
        ack0 = 1'b1;
        tick;
        ack0 = 1'b0;
        addr0 = 18'h00011;
        dst0 = 1'b1; din0 = 16'h5555;
        tick;
        chk("t4 no req while busy", 32'(req0), 32'd0);
        din0 = 16'h6666;
        tick;
        dst0 = 1'b0;
        chk("t4 ok stays low", 32'(ok0), 32'd0);
        chk("t4 first burst data", data0, 32'h66665555);
        tick;
        chk("t4 second req", 32'(req0), 32'd1);
        chk("t4 second addr", 32'(saddr0), 32'h22);
        q0.push_back(32'h88887777);
        ack0 = 1'b1;
        tick;
        ack0 = 1'b0;
        dst0 = 1'b1; din0 = 16'h7777;
        tick;
        din0 = 16'h8888;
        tick;
        dst0 = 1'b0;
        chk("t4 ok second", 32'(ok0), 32'd1);
        let_monitor;

        // 5: address wrap and ack coinciding with the first strobe
        addr1 = 18'h00001; cs1 = 1'b1;
        tick;
        chk("t5 req", 32'(req1), 32'd1);
        chk("t5 wrap addr", 32'(saddr1), 32'h0);
        q1.push_back(32'hBBBBAAAA);
        ack1 = 1'b1; dst1 = 1'b1; din1 = 16'hAAAA;
        tick;
        ack1 = 1'b0; dst1 = 1'b0;
        chk("t5 req drop", 32'(req1), 32'd0);
        chk("t5 ok low one beat", 32'(ok1), 32'd0);
        dst1 = 1'b1; din1 = 16'hBBBB;
        tick;
        dst1 = 1'b0;
        chk("t5 ok", 32'(ok1), 32'd1);
        let_monitor;

        // 6: reset while waiting for the second beat
        addr0 = 18'h00040;
        tick;
        chk("t6 req", 32'(req0), 32'd1);
        chk("t6 addr", 32'(saddr0), 32'h80);
        ack0 = 1'b1;
        tick;
        ack0 = 1'b0;
        dst0 = 1'b1; din0 = 16'h1111;
        tick;
        dst0 = 1'b0;
        cs0 = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6 rst req", 32'(req0), 32'd0);
        chk("t6 rst ok", 32'(ok0), 32'd0);
        chk("t6 rst data", data0, 32'd0);
        #1;
        rst = 1'b0;
        dst0 = 1'b1; din0 = 16'h2222;
        tick;
        dst0 = 1'b0;
        chk("t6 trailing dst ignored", data0, 32'd0);
        chk("t6 idle no req", 32'(req0), 32'd0);
        cs0 = 1'b1;
        #1;
        chk("t6 no stale ok", 32'(ok0), 32'd0);
        tick;
        chk("t6 fresh req", 32'(req0), 32'd1);
        q0.push_back(32'h44443333);
        ack0 = 1'b1;
        tick;
        ack0 = 1'b0;
        dst0 = 1'b1; din0 = 16'h3333;
        tick;
        din0 = 16'h4444;
        tick;
        dst0 = 1'b0;
        chk("t6 ok after refetch", 32'(ok0), 32'd1);
        let_monitor;

        repeat (3) tick;
        chk("q0 drained", 32'(q0.size()), 32'd0);
        chk("q1 drained", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
